data_memory_access: RTL and testbench

- Load/store unit sitting between the MEM pipeline stage and the data memory.
- Accepts one load or store request at a time. Drives a word-wide, wait-stated memory port with big-endian byte enables.
- Returns load data, sign- or zero-extended, to the writeback data select path.
- Ack timeout protects the pipeline against a hung memory.

---
 rtl/data_memory_access.sv | 214 +++++++++++++++++++++
 tb/tb_data_memory_access.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_access.sv
// -----------------------------------------------------------------------------
// data_memory_access
//
// Load/store unit between the MEM pipeline stage and a word-wide, wait-stated
// data memory. One request is in flight at a time (IDLE -> ACCESS -> RESP).
// The memory port uses big-endian byte enables: be[3] covers bits 31:24, which
// is byte offset 0. Load results are right-justified and sign- or
// zero-extended. An ack timeout turns a hung access into an error completion.
//
// Optional build macro: MEM_ALIGN_CHECK_EN
//   Defined   - misaligned half/word requests complete with an error straight
//               from IDLE without ever touching the memory.
//   Undefined - low address bits below the access size are ignored.
//
// Parameters:
//   TIMEOUT        ACCESS cycles allowed without in_mem_ack (1..255)
//
// Ports:
//   in_clk, in_rst_n          clock, synchronous active-low reset
//   in_req_valid/out_req_ready request handshake
//   in_we, in_size, in_signed request kind, size (00 B, 01 H, 1x W), sign-ext
//   in_addr, in_wdata         byte address, right-justified store data
//   out_rsp_valid/_err        one-cycle completion pulse and error flag
//   out_rdata                 formatted load data (0 for stores/errors)
//   out_mem_en/we/be/addr/wdata  memory request, held through ACCESS
//   in_mem_ack, in_mem_rdata  memory completion and read word
// -----------------------------------------------------------------------------
module data_memory_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_req_valid,
    output logic        out_req_ready,
    input  logic        in_we,
    input  logic [1:0]  in_size,
    input  logic        in_signed,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        out_rsp_valid,
    output logic        out_rsp_err,
    output logic [31:0] out_rdata,
    output logic        out_mem_en,
    output logic        out_mem_we,
    output logic [3:0]  out_mem_be,
    output logic [31:0] out_mem_addr,
    output logic [31:0] out_mem_wdata,
    input  logic        in_mem_ack,
    input  logic [31:0] in_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Last counter value before the access is declared hung.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        sgn_q;

    logic        rdy_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rdata_q;
    logic        mem_en_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_d;
    logic        misaligned;

    // Byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = in_wdata;
        case (in_size)
            2'b00: begin
                be_d    = 4'b1000 >> in_addr[1:0];
                wdata_d = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                be_d    = in_addr[1] ? 4'b0011 : 4'b1100;
                wdata_d = {2{in_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load formatting uses the request latched at accept time, since the
    // request inputs are free to change while the access is in flight.
    always_comb begin
        lane_b = in_mem_rdata[7:0];
        case (off_q)
            2'd0:    lane_b = in_mem_rdata[31:24];
            2'd1:    lane_b = in_mem_rdata[23:16];
            2'd2:    lane_b = in_mem_rdata[15:8];
            default: lane_b = in_mem_rdata[7:0];
        endcase
        lane_h = off_q[1] ? in_mem_rdata[15:0] : in_mem_rdata[31:16];
        case (size_q)
            2'b00:   ld_d = {{24{sgn_q & lane_b[7]}}, lane_b};
            2'b01:   ld_d = {{16{sgn_q & lane_h[15]}}, lane_h};
            default: ld_d = in_mem_rdata;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (in_size == 2'b01) ? in_addr[0]
                      : (in_size[1] ? (in_addr[1:0] != 2'b00) : 1'b0);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            sgn_q       <= 1'b0;
            rdy_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= 32'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_req_valid) begin
                        size_q <= in_size;
                        off_q  <= in_addr[1:0];
                        sgn_q  <= in_signed;
                        rdy_q  <= 1'b0;
                        if (misaligned) begin
                            // Rejected without a memory cycle.
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rdata_q     <= 32'd0;
                        end else begin
                            state_q     <= ACCESS;
                            cnt_q       <= 8'd0;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= in_we;
                            mem_be_q    <= be_d;
                            mem_addr_q  <= {in_addr[31:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                        end
                    end
                end
                ACCESS: begin
                    // Ack is checked first so an ack on the final allowed
                    // cycle completes normally rather than as a timeout.
                    if (in_mem_ack) begin
                        state_q     <= RESP;
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rdata_q     <= mem_we_q ? 32'd0 : ld_d;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= RESP;
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rdata_q     <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                    cnt_q   <= 8'd0;
                end
                default: begin
                    state_q  <= IDLE;
                    rdy_q    <= 1'b1;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_req_ready = rdy_q;
    assign out_rsp_valid = rsp_valid_q;
    assign out_rsp_err   = rsp_err_q;
    assign out_rdata     = rdata_q;
    assign out_mem_en    = mem_en_q;
    assign out_mem_we    = mem_we_q;
    assign out_mem_be    = mem_be_q;
    assign out_mem_addr  = mem_addr_q;
    assign out_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_memory_access.sv
// -----------------------------------------------------------------------------
// tb_data_memory_access
//
// Directed vector table plus randomized transactions for data_memory_access,
// checked against a reference model of the byte-lane, extension, latency and
// timeout rules. Also covers reset state and reset in the middle of an access.
// -----------------------------------------------------------------------------
module tb_data_memory_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sgn = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    logic        req_ready, rsp_valid, rsp_err, mem_en, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    data_memory_access #(.TIMEOUT(TO)) dut (
        .in_clk        (clk),
        .in_rst_n      (rst_n),
        .in_req_valid  (req_valid),
        .out_req_ready (req_ready),
        .in_we         (we),
        .in_size       (size),
        .in_signed     (sgn),
        .in_addr       (addr),
        .in_wdata      (wdata),
        .out_rsp_valid (rsp_valid),
        .out_rsp_err   (rsp_err),
        .out_rdata     (rdata),
        .out_mem_en    (mem_en),
        .out_mem_we    (mem_we),
        .out_mem_be    (mem_be),
        .out_mem_addr  (mem_addr),
        .out_mem_wdata (mem_wdata),
        .in_mem_ack    (mem_ack),
        .in_mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;       // ACCESS cycles before ack; >= TO means never in time
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] rexp;
        logic        err;
        int          en;        // cycles out_mem_en is high
        int          lat;       // cycles from accept edge to out_rsp_valid
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] s, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int d,
                                input logic [3:0] be, input logic [31:0] ma,
                                input logic [31:0] mwd, input logic [31:0] rx,
                                input logic er, input int en, input int lat);
        vec_t v;
        v.we = w; v.size = s; v.sgn = sg; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.dly = d; v.be = be; v.maddr = ma; v.mwdata = mwd; v.rexp = rx;
        v.err = er; v.en = en; v.lat = lat;
        return v;
    endfunction

    // Reference model: expected outputs from the lane/extension/timeout rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int off = int'(v.addr[1:0]);
        int hi  = off / 2;
        logic [31:0] val;
        logic mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (v.size == 2'd1 && off % 2 != 0) || (v.size >= 2'd2 && off != 0);
`endif
        r.maddr = v.addr & ~32'h3;
        if (v.size == 2'd0) begin
            r.be     = 4'(1 << (3 - off));
            r.mwdata = (v.wdata & 32'hFF) * 32'h0101_0101;
            val      = (v.rdata >> (8 * (3 - off))) & 32'hFF;
            if (v.sgn && val >= 32'h80) val = val | 32'hFFFF_FF00;
        end else if (v.size == 2'd1) begin
            r.be     = (hi != 0) ? 4'b0011 : 4'b1100;
            r.mwdata = (v.wdata & 32'hFFFF) * 32'h0001_0001;
            val      = (v.rdata >> (16 * (1 - hi))) & 32'hFFFF;
            if (v.sgn && val >= 32'h8000) val = val | 32'hFFFF_0000;
        end else begin
            r.be     = 4'hF;
            r.mwdata = v.wdata;
            val      = v.rdata;
        end
        if (mis) begin
            r.en = 0; r.lat = 1; r.err = 1'b1; r.rexp = 32'd0;
        end else if (v.dly >= TO) begin
            r.en = TO; r.lat = TO + 1; r.err = 1'b1; r.rexp = 32'd0;
        end else begin
            r.en = v.dly + 1; r.lat = v.dly + 2; r.err = 1'b0;
            r.rexp = v.we ? 32'd0 : val;
        end
        return r;
    endfunction

    // Observations from the last transaction.
    int          r_en, r_lat;
    logic [3:0]  r_be;
    logic [31:0] r_maddr, r_mwdata, r_rdata, r_rdata_hold;
    logic        r_mwe, r_stable, r_err, r_rdy_ok, r_rdy_after, r_rsp_again, r_en_at_rsp;

    task automatic run_txn(input vec_t v);
        int cyc, k;
        logic got, first;
        r_rdy_ok = req_ready;
        req_valid = 1'b1; we = v.we; size = v.size; sgn = v.sgn;
        addr = v.addr; wdata = v.wdata;
        @(posedge clk); #1;
        // Scramble request inputs: the unit must work from its latched copy.
        req_valid = 1'b0; we = 1'($urandom); size = 2'($urandom); sgn = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        cyc = 1; k = 0; got = 1'b0; first = 1'b1;
        r_en = 0; r_lat = -1; r_stable = 1'b1; r_en_at_rsp = 1'b0;
        r_be = 4'h0; r_maddr = 32'd0; r_mwdata = 32'd0; r_mwe = 1'b0;
        r_err = 1'bx; r_rdata = 32'hx;
        while (cyc < 40 && !got) begin
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (rsp_valid) begin
                got = 1'b1; r_lat = cyc; r_err = rsp_err; r_rdata = rdata;
                r_en_at_rsp = mem_en;
                if (req_ready) r_rdy_ok = 1'b0;
            end else begin
                if (req_ready) r_rdy_ok = 1'b0;
                if (mem_en) begin
                    if (first) begin
                        r_be = mem_be; r_maddr = mem_addr; r_mwdata = mem_wdata; r_mwe = mem_we;
                        first = 1'b0;
                    end else if (mem_be !== r_be || mem_addr !== r_maddr ||
                                 mem_wdata !== r_mwdata || mem_we !== r_mwe) begin
                        r_stable = 1'b0;
                    end
                    if (k == v.dly) begin
                        mem_ack = 1'b1; mem_rdata = v.rdata;
                    end
                    k++; r_en++;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        mem_ack = 1'b0;
        @(posedge clk); #1;
        r_rdy_after  = req_ready;
        r_rsp_again  = rsp_valid;
        r_rdata_hold = rdata;
    endtask

    task automatic cmp_txn(input string tag, input vec_t v);
        chk({tag, ".lat"}, 32'(r_lat), 32'(v.lat));
        chk({tag, ".en_cycles"}, 32'(r_en), 32'(v.en));
        chk({tag, ".err"}, {31'd0, r_err}, {31'd0, v.err});
        chk({tag, ".rdata"}, r_rdata, v.rexp);
        chk({tag, ".rdata_hold"}, r_rdata_hold, v.rexp);
        chk({tag, ".busy_not_ready"}, {31'd0, r_rdy_ok}, 32'd1);
        chk({tag, ".en_low_in_resp"}, {31'd0, r_en_at_rsp}, 32'd0);
        chk({tag, ".ready_after"}, {31'd0, r_rdy_after}, 32'd1);
        chk({tag, ".single_pulse"}, {31'd0, r_rsp_again}, 32'd0);
        if (v.en > 0) begin
            chk({tag, ".be"}, {28'd0, r_be}, {28'd0, v.be});
            chk({tag, ".maddr"}, r_maddr, v.maddr);
            chk({tag, ".mem_we"}, {31'd0, r_mwe}, {31'd0, v.we});
            chk({tag, ".stable"}, {31'd0, r_stable}, 32'd1);
            if (v.we) chk({tag, ".mwdata"}, r_mwdata, v.mwdata);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, ".rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, ".mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({tag, ".mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, ".mem_be"}, {28'd0, mem_be}, 32'd0);
        chk({tag, ".rdata"}, rdata, 32'd0);
        chk({tag, ".mem_addr"}, mem_addr, 32'd0);
        chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    endtask

    vec_t tbl[14];

    initial begin
        // Expected values worked out by hand for TIMEOUT = 4.
        tbl[0]  = mk(1, 2'd0, 0, 32'h102, 32'h0000_00A5, 32'h0, 0,
                     4'b0010, 32'h100, 32'hA5A5_A5A5, 32'h0, 0, 1, 2);
        tbl[1]  = mk(0, 2'd1, 1, 32'h2, 32'h0, 32'h1234_8001, 3,
                     4'b0011, 32'h0, 32'h0, 32'hFFFF_8001, 0, 4, 5);
        tbl[2]  = mk(0, 2'd1, 0, 32'h2, 32'h0, 32'h1234_8001, 3,
                     4'b0011, 32'h0, 32'h0, 32'h0000_8001, 0, 4, 5);
        tbl[3]  = mk(0, 2'd2, 0, 32'h10, 32'h0, 32'h5555_5555, 255,
                     4'b1111, 32'h10, 32'h0, 32'h0, 1, 4, 5);
        tbl[4]  = mk(0, 2'd2, 0, 32'h4, 32'h0, 32'hDEAD_BEEF, 1,
                     4'b1111, 32'h4, 32'h0, 32'hDEAD_BEEF, 0, 2, 3);
        tbl[5]  = mk(0, 2'd0, 1, 32'h3, 32'h0, 32'h0000_00F0, 0,
                     4'b0001, 32'h0, 32'h0, 32'hFFFF_FFF0, 0, 1, 2);
        tbl[6]  = mk(0, 2'd0, 0, 32'h1, 32'h0, 32'h00AB_0000, 2,
                     4'b0100, 32'h0, 32'h0, 32'h0000_00AB, 0, 3, 4);
        tbl[7]  = mk(1, 2'd1, 0, 32'h6, 32'h1234_BEEF, 32'h0, 1,
                     4'b0011, 32'h4, 32'hBEEF_BEEF, 32'h0, 0, 2, 3);
        tbl[8]  = mk(1, 2'd2, 0, 32'h20, 32'hCAFE_F00D, 32'h0, 0,
                     4'b1111, 32'h20, 32'hCAFE_F00D, 32'h0, 0, 1, 2);
        tbl[9]  = mk(0, 2'd2, 1, 32'h40, 32'h0, 32'h8000_0001, 0,
                     4'b1111, 32'h40, 32'h0, 32'h8000_0001, 0, 1, 2);
        tbl[10] = mk(1, 2'd3, 0, 32'h8, 32'h0102_0304, 32'h0, 2,
                     4'b1111, 32'h8, 32'h0102_0304, 32'h0, 0, 3, 4);
        tbl[11] = mk(1, 2'd0, 1, 32'h7, 32'hFFFF_FF3C, 32'h0, 3,
                     4'b0001, 32'h4, 32'h3C3C_3C3C, 32'h0, 0, 4, 5);
`ifdef MEM_ALIGN_CHECK_EN
        tbl[12] = mk(0, 2'd2, 0, 32'h6, 32'h0, 32'h1122_3344, 0,
                     4'b1111, 32'h4, 32'h0, 32'h0, 1, 0, 1);
        tbl[13] = mk(0, 2'd1, 0, 32'h3, 32'h0, 32'hAAAA_5555, 1,
                     4'b0011, 32'h0, 32'h0, 32'h0, 1, 0, 1);
`else
        tbl[12] = mk(0, 2'd2, 0, 32'h6, 32'h0, 32'h1122_3344, 0,
                     4'b1111, 32'h4, 32'h0, 32'h1122_3344, 0, 1, 2);
        tbl[13] = mk(0, 2'd1, 0, 32'h3, 32'h0, 32'hAAAA_5555, 1,
                     4'b0011, 32'h0, 32'h0, 32'h0000_5555, 0, 2, 3);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            run_txn(tbl[i]);
            cmp_txn($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset in the middle of an access, then a stray ack afterwards.
        run_txn(tbl[4]);
        cmp_txn("pre_rst", tbl[4]);
        req_valid = 1'b1; we = 1'b0; size = 2'd2; sgn = 1'b0; addr = 32'h30;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_rst.in_access", {31'd0, mem_en}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("mid_rst");
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        begin
            int seen = 0;
            for (int c = 0; c < 5; c++) begin
                if (rsp_valid || mem_en) seen++;
                @(posedge clk); #1;
            end
            chk("late_ack.ignored", 32'(seen), 32'd0);
        end
        chk_reset_vals("after_late_ack");
        run_txn(tbl[1]);
        cmp_txn("post_rst", tbl[1]);

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.we    = 1'($urandom);
            v.size  = 2'($urandom);
            v.sgn   = 1'($urandom);
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.dly   = int'($urandom_range(0, 5));
            v = model(v);
            run_txn(v);
            cmp_txn($sformatf("rnd%0d", i), v);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
